// File: rtl/sum_accum_pkg.sv
// Shared types and helpers for the sum_accum multi-channel summing accumulator.
// Optional output saturation is enabled by defining SUM_ACCUM_SAT_EN.
package sum_accum_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Upper bounds for the packed operand bus and the reduced sum handled by lane_sum.
   localparam int MAX_DATA_W = 1024;
   localparam int MAX_SUM_W  = 64;

   function automatic int result_width(input int width, input int channels, input int beats);
      return width + $clog2(channels) + $clog2(beats);
   endfunction

   // Zero-extends each WIDTH-bit channel of the packed beat and adds them all.
   function automatic logic [MAX_SUM_W-1:0] lane_sum(
      input logic [MAX_DATA_W-1:0] data,
      input int                    width,
      input int                    channels
   );
      logic [MAX_SUM_W-1:0] mask;
      logic [MAX_SUM_W-1:0] lane;
      logic [MAX_SUM_W-1:0] total;
      mask  = (MAX_SUM_W'(1) << width) - MAX_SUM_W'(1);
      total = '0;
      for (int c = 0; c < channels; c++) begin
         lane  = MAX_SUM_W'(data >> (c * width)) & mask;
         total = total + lane;
      end
      return total;
   endfunction

endpackage

// File: rtl/sum_accum_if.sv
// Valid/ready input and output channels of sum_accum; master drives beats, slave is the block.
interface sum_accum_if
   import sum_accum_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int BEATS    = 4
);
   localparam int OW = result_width(WIDTH, CHANNELS, BEATS);

   logic                      in_valid;
   logic                      in_ready;
   logic [CHANNELS*WIDTH-1:0] in_data;
   logic                      out_valid;
   logic                      out_ready;
   logic [OW-1:0]             out_sum;
   logic                      out_sat;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_sum, out_sat
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_sum, out_sat
   );

endinterface

// File: rtl/sum_accum.sv
// Accumulates BEATS beats of CHANNELS operands each into one result with valid/ready on both sides.
// Define SUM_ACCUM_SAT_EN to clamp the presented result to 2**WIDTH-1 and flag it on out_sat.
module sum_accum
   import sum_accum_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int BEATS    = 4
)(
   input  logic       clk,
   input  logic       rst,
   sum_accum_if.slave bus
);

   localparam int OW = result_width(WIDTH, CHANNELS, BEATS);
   localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

   state_t        state_r;
   state_t        next_state_s;
   logic [OW-1:0] acc_r;
   logic [CW-1:0] count_r;
   logic          accept_s;
   logic          handshake_s;
   logic          last_beat_s;
   logic [OW-1:0] out_sum_s;

   assign bus.in_ready  = (state_r != DONE);
   assign bus.out_valid = (state_r == DONE);
   assign accept_s      = bus.in_valid & bus.in_ready;
   assign handshake_s   = bus.out_valid & bus.out_ready;
   assign last_beat_s   = (count_r == CW'(BEATS - 1));

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state: a beat that completes the group moves to DONE, even straight from IDLE.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               next_state_s = last_beat_s ? DONE : ACCUM;
            end else begin
               next_state_s = IDLE;
            end
         end
         ACCUM: begin
            if (accept_s && last_beat_s) begin
               next_state_s = DONE;
            end else begin
               next_state_s = ACCUM;
            end
         end
         DONE: begin
            if (handshake_s) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = DONE;
            end
         end
         default: next_state_s = IDLE;
      endcase
   end

   // Accumulator and beat counter; the counter wraps on the last beat so it is already clear in DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_r   <= '0;
         count_r <= '0;
      end else if (accept_s) begin
         acc_r <= acc_r + OW'(lane_sum(MAX_DATA_W'(bus.in_data), WIDTH, CHANNELS));
         if (last_beat_s) begin
            count_r <= '0;
         end else begin
            count_r <= count_r + CW'(1);
         end
      end else if (handshake_s) begin
         acc_r   <= '0;
         count_r <= '0;
      end
   end

`ifdef SUM_ACCUM_SAT_EN
   localparam logic [OW-1:0] SAT_MAX = OW'({WIDTH{1'b1}});

   logic out_sat_s;

   // Result presentation with clamp; acc_r itself keeps full precision.
   always_comb begin
      out_sum_s = '0;
      out_sat_s = 1'b0;
      if (state_r == DONE) begin
         if (acc_r > SAT_MAX) begin
            out_sum_s = SAT_MAX;
            out_sat_s = 1'b1;
         end else begin
            out_sum_s = acc_r;
            out_sat_s = 1'b0;
         end
      end else begin
         out_sum_s = '0;
         out_sat_s = 1'b0;
      end
   end

   assign bus.out_sat = out_sat_s;
`else
   // Result presentation: the full-width accumulator while DONE, zero otherwise.
   always_comb begin
      out_sum_s = '0;
      if (state_r == DONE) begin
         out_sum_s = acc_r;
      end else begin
         out_sum_s = '0;
      end
   end

   assign bus.out_sat = 1'b0;
`endif

   assign bus.out_sum = out_sum_s;

endmodule

// File: tb/tb_sum_accum.sv
// Directed, table-driven bench for sum_accum (WIDTH=8, CHANNELS=4, BEATS=4).
// Expectations follow SUM_ACCUM_SAT_EN when it is defined for the build.
module tb_sum_accum;
   import sum_accum_pkg::*;

   localparam int WIDTH    = 8;
   localparam int CHANNELS = 4;
   localparam int BEATS    = 4;

   logic clk;
   logic rst;

   sum_accum_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .BEATS(BEATS)) bus ();

   sum_accum #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .BEATS(BEATS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [31:0] beats [4];
      int          full;
   } vec_t;

   vec_t vecs [6];
   int   n_checks = 0;
   int   n_fail   = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Holds a beat on the bus until it is accepted; returns #1 after the accepting edge.
   task automatic drive_beat(input logic [31:0] data);
      logic accepted;
      accepted     = 1'b0;
      bus.in_data  = data;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 50 && !accepted; i++) begin
         accepted = bus.in_ready;
         @(posedge clk);
         #1;
      end
      chk("beat_accepted", {31'd0, accepted}, 32'd1);
   endtask

   // Called #1 after the final accepting edge: result must already be valid, then it is consumed.
   task automatic expect_result(input string name, input int full);
      int exp_sum;
      int exp_sat;
`ifdef SUM_ACCUM_SAT_EN
      exp_sum = (full > 255) ? 255 : full;
      exp_sat = (full > 255) ? 1 : 0;
`else
      exp_sum = full;
      exp_sat = 0;
`endif
      bus.in_valid = 1'b0;
      chk({name, "_out_valid"}, {31'd0, bus.out_valid}, 32'd1);
      chk({name, "_in_ready_done"}, {31'd0, bus.in_ready}, 32'd0);
      chk({name, "_out_sum"}, 32'(bus.out_sum), 32'(exp_sum));
      chk({name, "_out_sat"}, {31'd0, bus.out_sat}, 32'(exp_sat));
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      chk({name, "_valid_cleared"}, {31'd0, bus.out_valid}, 32'd0);
      chk({name, "_in_ready_back"}, {31'd0, bus.in_ready}, 32'd1);
      chk({name, "_sum_cleared"}, 32'(bus.out_sum), 32'd0);
   endtask

   initial begin
      vecs[0] = '{'{32'h04030201, 32'h04030201, 32'h04030201, 32'h04030201}, 40};
      vecs[1] = '{'{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF}, 4080};
      vecs[2] = '{'{32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000}, 0};
      vecs[3] = '{'{32'h000000FF, 32'h00000000, 32'h00000000, 32'h00000000}, 255};
      vecs[4] = '{'{32'h000001FF, 32'h00000000, 32'h00000000, 32'h00000000}, 256};
      vecs[5] = '{'{32'h281E140A, 32'h01020304, 32'h00000000, 32'h80000000}, 238};

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("reset_out_sum", 32'(bus.out_sum), 32'd0);
      chk("reset_out_sat", {31'd0, bus.out_sat}, 32'd0);

      // Back-to-back beats per table entry; no result may appear before the last beat.
      for (int v = 0; v < 6; v++) begin
         for (int b = 0; b < 4; b++) begin
            drive_beat(vecs[v].beats[b]);
            if (b == 2) begin
               chk($sformatf("vec%0d_early_valid", v), {31'd0, bus.out_valid}, 32'd0);
            end
         end
         expect_result($sformatf("vec%0d", v), vecs[v].full);
      end

      // Asynchronous reset asserted mid-cycle while a result is pending.
      for (int b = 0; b < 4; b++) begin
         drive_beat(32'h04030201);
      end
      bus.in_valid = 1'b0;
      chk("pre_reset_valid", {31'd0, bus.out_valid}, 32'd1);
      #3;
      rst = 1'b1;
      #1;
      chk("async_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("async_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("async_rst_out_sum", 32'(bus.out_sum), 32'd0);
      chk("async_rst_out_sat", {31'd0, bus.out_sat}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Backpressure: result held for 5 cycles while the producer keeps offering a beat.
      for (int b = 0; b < 4; b++) begin
         drive_beat(32'h04030201);
      end
      bus.in_data = 32'h09090909;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         chk($sformatf("bp%0d_out_valid", c), {31'd0, bus.out_valid}, 32'd1);
         chk($sformatf("bp%0d_out_sum", c), 32'(bus.out_sum), 32'd40);
         chk($sformatf("bp%0d_in_ready", c), {31'd0, bus.in_ready}, 32'd0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      chk("bp_release_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("bp_release_in_ready", {31'd0, bus.in_ready}, 32'd1);

      // Gapped beats; also proves no stray beat was taken during backpressure.
      for (int b = 0; b < 4; b++) begin
         drive_beat(32'h01010101);
         bus.in_valid = 1'b0;
         if (b < 3) begin
            chk($sformatf("gap_beat%0d_no_valid", b), {31'd0, bus.out_valid}, 32'd0);
            repeat (2) @(posedge clk);
            #1;
         end
      end
      expect_result("gapped", 16);

      // Reset after a partial group must discard the partial sum.
      drive_beat(32'h09090909);
      drive_beat(32'h09090909);
      bus.in_valid = 1'b0;
      rst = 1'b1;
      #2;
      rst = 1'b0;
      for (int b = 0; b < 4; b++) begin
         drive_beat(32'h00000001);
         if (b == 1) begin
            chk("post_reset_no_stale_valid", {31'd0, bus.out_valid}, 32'd0);
         end
      end
      expect_result("post_reset", 4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
